// File: rtl/four2two_rr_enc.sv
// four2two_rr_enc: sequential 4-to-2 encoder with request latching and valid/ready output.
// Requests on d0..d3 are merged into a pending mask; each pending index is issued once on
// x1:x0, either round-robin (starting after the last served index) or fixed priority (d0 first).
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   d0..d3           request lines, one request per high cycle
//   valid, ready     output handshake; transfer when valid && ready at a clock edge
//   x1, x0           encoded pending index (MSB, LSB)
//   dup              one-cycle registered pulse: request hit an index already pending
//   served_cnt       saturating count of completed handshakes
module four2two_rr_enc #(
    parameter bit          RR_EN = 1'b1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d0,
    input  logic             d1,
    input  logic             d2,
    input  logic             d3,
    input  logic             ready,
    output logic             valid,
    output logic             x0,
    output logic             x1,
    output logic             dup,
    output logic [CNT_W-1:0] served_cnt
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [3:0]       pending_q, pending_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       x_q, x_d;
    logic             valid_q, valid_d;
    logic             dup_q, dup_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]       req;
    logic             fire;
    logic [3:0]       clr;
    logic [3:0]       rem;
    logic [1:0]       next_ptr;

    // First set bit of p, searching start, start+1, ... modulo 4.
    function automatic logic [1:0] sel_idx(input logic [3:0] p, input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] res;
        res = start;
        // Walk the search order backwards so the earliest hit is written last.
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (p[idx]) begin
                res = idx;
            end
        end
        return res;
    endfunction

    // Next-state, pending-mask and output computation.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        valid_d   = valid_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;

        req       = {d3, d2, d1, d0};
        fire      = valid_q && ready;
        clr       = fire ? (4'b0001 << x_q) : 4'b0000;
        rem       = pending_q & ~clr;
        // A new request on the bit being served re-sets it, so it is issued again.
        pending_d = rem | req;
        dup_d     = |(req & rem);
        next_ptr  = x_q + 2'd1;

        case (state_q)
            IDLE: begin
                if (pending_q != 4'b0000) begin
                    x_d     = sel_idx(pending_q, RR_EN ? ptr_q : 2'd0);
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (ready) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    ptr_d = next_ptr;
                    // Back-to-back issue from the mask left after this transfer.
                    if (rem != 4'b0000) begin
                        x_d = sel_idx(rem, RR_EN ? next_ptr : 2'd0);
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 4'b0000;
            ptr_q     <= 2'd0;
            x_q       <= 2'd0;
            valid_q   <= 1'b0;
            dup_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            x_q       <= x_d;
            valid_q   <= valid_d;
            dup_q     <= dup_d;
            cnt_q     <= cnt_d;
        end
    end

    assign valid      = valid_q;
    assign x0         = x_q[0];
    assign x1         = x_q[1];
    assign dup        = dup_q;
    assign served_cnt = cnt_q;

endmodule
